fifo_event_arbiter: RTL and testbench
=====================================

// Module: fifo_event_arbiter
// PURPOSE
//  Round-robin scheduler that shares the single outgoing FIFO write port among TX/RX event sources.
//  Sources are TX config, TX status, RX config and RX data/status.
//  Each source pulse captures a payload into a per-source holding register.
//  Pending payloads are pushed one at a time as {tag, payload} words; the tag is the source index.
//  Sits between the TX/RX change-notification outputs and the write side of the host FIFO.
// PARAMETERS
//  NUM_SRC  4   number of event sources
//  DATA_W   32  payload width per source
//  TAG_W    2   tag width; 2**TAG_W >= NUM_SRC
// PORTS
//  clk              in   1                 system clock, rising edge
//  rst_n            in   1                 asynchronous active-low reset
//  ev_valid         in   NUM_SRC           one-cycle event pulse per source
//  ev_data          in   NUM_SRC*DATA_W    payloads; source i occupies [i*DATA_W +: DATA_W]
//  fifo_write_full  in   1                 write FIFO full
//  fifo_write_data  out  TAG_W+DATA_W      {tag, payload}
//  fifo_write_inc   out  1                 one-cycle push strobe
//  overrun          out  NUM_SRC           sticky: a pending payload was overwritten
//  overrun_clr      in   NUM_SRC           clears the matching overrun bits
//  busy             out  1                 any source pending, or fifo_write_inc high
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - outputs: fifo_write_data=0, fifo_write_inc=0, overrun=0, busy=0
//   - internal: all pending=0, holding regs=0, rr_ptr=NUM_SRC-1 (source 0 wins first)
//   - reset mid-operation discards every pending event and any push not yet strobed
//  Capture, on a clock edge with ev_valid[i]=1:
//   - hold[i] <= ev_data[i]; pending[i] <= 1
//  Grant, combinational within a cycle:
//   - eligible = pending & ~fifo_write_full & ~fifo_write_inc
//   - fifo_write_inc high blocks a grant, so pushes are never back-to-back; max throughput is 1 word / 2 clk
//   - winner = first pending index scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_SRC
//  On the edge after a grant to source g:
//   - fifo_write_data <= {g[TAG_W-1:0], hold[g]}; fifo_write_inc <= 1 for exactly one cycle
//   - pending[g] <= 0; rr_ptr <= g
//  fifo_write_data holds its last value when fifo_write_inc=0.
//  Latency: ev_valid sampled at edge E with no competition and FIFO not full -> fifo_write_inc high after edge E+1.
//  Full: while fifo_write_full=1, no grant; pending payloads and rr_ptr are kept; no data is lost.
//  Same source, same edge:
//   - ev_valid[i] with pending[i]=1 and i not granted: hold[i] is overwritten (latest wins); overrun[i] <= 1
//   - ev_valid[i] on the edge that grants i: old hold[i] is pushed; new payload captured; pending[i] stays 1; no overrun
//  overrun_clr[i] with a simultaneous overrun set: the set wins.
//  Multiple ev_valid on one edge: all are captured and drained in round-robin order.
//  Tag values NUM_SRC..2**TAG_W-1 are never produced.
// TESTING
//  1 Single event: ev_valid=0001, ev_data[0]=87 -> fifo_write_inc for 1 cycle, one edge after capture; fifo_write_data=34'h0_00000057.
//  2 Simultaneous sources: ev_valid=1111 with payloads 87/97/1/77 -> pushes with tags 0,1,2,3 on alternate cycles; busy=0 after the last push.
//  3 Full back-pressure: fifo_write_full=1 for 20 cycles while events arrive -> no fifo_write_inc.
//    Release -> all payloads are emitted in rr order, with no loss.
//  4 Overrun: two ev_valid[2] pulses (17, then 47) while full -> one push of tag 2 / payload 47; overrun=0100.
//    overrun_clr[2] -> overrun=0.
//  5 Coincident event/grant: ev_valid[1] on the granting edge -> old payload then new payload, both pushed; overrun stays 0.
//  6 Reset mid-operation: rst_n low while 3 sources are pending -> outputs 0 immediately.
//    After release: no pushes until a new event; the first winner is source 0.

Source files
------------

// File: rtl/fifo_event_arbiter.sv
// fifo_event_arbiter: round-robin arbiter pushing per-source event payloads as {tag, payload} into one FIFO write port
module fifo_event_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        ev_valid,
  input  logic [NUM_SRC*DATA_W-1:0] ev_data,
  input  logic                      fifo_write_full,
  output logic [TAG_W+DATA_W-1:0]   fifo_write_data,
  output logic                      fifo_write_inc,
  output logic [NUM_SRC-1:0]        overrun,
  input  logic [NUM_SRC-1:0]        overrun_clr,
  output logic                      busy
);
  logic [DATA_W-1:0]  hold [NUM_SRC];
  logic [NUM_SRC-1:0] pending, eligible, gnt_vec;
  logic [TAG_W-1:0]   rr_ptr, gnt;
  logic               gnt_any;
  // a push in flight blocks the next grant, so pushes are never back-to-back
  assign eligible = (fifo_write_full || fifo_write_inc) ? '0 : pending;
  assign busy = |pending || fifo_write_inc;
  always_comb begin
    gnt_any = 1'b0;
    gnt = '0;
    gnt_vec = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      if (!gnt_any && eligible[TAG_W'((int'(rr_ptr) + k) % NUM_SRC)]) begin
        gnt_any = 1'b1;
        gnt = TAG_W'((int'(rr_ptr) + k) % NUM_SRC);
        gnt_vec[TAG_W'((int'(rr_ptr) + k) % NUM_SRC)] = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      overrun <= '0;
      rr_ptr <= TAG_W'(NUM_SRC - 1);
      fifo_write_data <= '0;
      fifo_write_inc <= 1'b0;
      for (int i = 0; i < NUM_SRC; i++) hold[i] <= '0;
    end else begin
      fifo_write_inc <= gnt_any;
      if (gnt_any) begin
        fifo_write_data <= {gnt, hold[gnt]};
        rr_ptr <= gnt;
      end
      // a new pulse on the granting edge re-arms pending; set beats clear on overrun
      for (int i = 0; i < NUM_SRC; i++) begin
        if (ev_valid[i]) hold[i] <= ev_data[i*DATA_W +: DATA_W];
        pending[i] <= ev_valid[i] | (pending[i] & ~gnt_vec[i]);
        overrun[i] <= (ev_valid[i] & pending[i] & ~gnt_vec[i]) | (overrun[i] & ~overrun_clr[i]);
      end
    end
  end
endmodule

// File: tb/tb_fifo_event_arbiter.sv
// tb_fifo_event_arbiter: table-driven cycle vectors plus directed back-pressure and reset sequences
module tb_fifo_event_arbiter;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   ev_valid = '0;
  logic [127:0] ev_data = '0;
  logic         fifo_write_full = 1'b0;
  logic [33:0]  fifo_write_data;
  logic         fifo_write_inc;
  logic [3:0]   overrun;
  logic [3:0]   overrun_clr = '0;
  logic         busy;
  int n_cmp = 0;
  int n_bad = 0;

  fifo_event_arbiter dut (
    .clk(clk), .rst_n(rst_n), .ev_valid(ev_valid), .ev_data(ev_data),
    .fifo_write_full(fifo_write_full), .fifo_write_data(fifo_write_data),
    .fifo_write_inc(fifo_write_inc), .overrun(overrun), .overrun_clr(overrun_clr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   ev;
    logic [127:0] data;
    logic         full;
    logic [3:0]   clr;
    logic         inc;
    logic [33:0]  wdata;
    logic [3:0]   ov;
    logic         busy;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic [3:0] ev, input logic [31:0] d3, d2, d1, d0,
                              input logic full, input logic [3:0] clr, input logic inc,
                              input logic [33:0] wdata, input logic [3:0] ov, input logic bsy);
    vec_t v;
    v.ev = ev; v.data = {d3, d2, d1, d0}; v.full = full; v.clr = clr;
    v.inc = inc; v.wdata = wdata; v.ov = ov; v.busy = bsy;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [33:0] pushes[$];
    logic [33:0] exp_push[4];
    int incs;
    logic prev_inc;
    logic b2b;

    // simultaneous sources drain 0..3 on alternate cycles
    add(4'b1111, 77, 1, 97, 87, 0, 4'b0000, 0, 34'h0,          4'b0000, 1);
    add(4'b0000,  0, 0,  0,  0, 0, 4'b0000, 1, 34'h0_00000057, 4'b0000, 1);
    add(4'b0000,  0, 0,  0,  0, 0, 4'b0000, 0, 34'h0_00000057, 4'b0000, 1);
    add(4'b0000,  0, 0,  0,  0, 0, 4'b0000, 1, 34'h1_00000061, 4'b0000, 1);
    add(4'b0000,  0, 0,  0,  0, 0, 4'b0000, 0, 34'h1_00000061, 4'b0000, 1);
    add(4'b0000,  0, 0,  0,  0, 0, 4'b0000, 1, 34'h2_00000001, 4'b0000, 1);
    add(4'b0000,  0, 0,  0,  0, 0, 4'b0000, 0, 34'h2_00000001, 4'b0000, 1);
    add(4'b0000,  0, 0,  0,  0, 0, 4'b0000, 1, 34'h3_0000004D, 4'b0000, 1);
    add(4'b0000,  0, 0,  0,  0, 0, 4'b0000, 0, 34'h3_0000004D, 4'b0000, 0);
    // single event, one-edge latency
    add(4'b0001,  0, 0,  0, 87, 0, 4'b0000, 0, 34'h3_0000004D, 4'b0000, 1);
    add(4'b0000,  0, 0,  0,  0, 0, 4'b0000, 1, 34'h0_00000057, 4'b0000, 1);
    add(4'b0000,  0, 0,  0,  0, 0, 4'b0000, 0, 34'h0_00000057, 4'b0000, 0);
    // overrun while full, then clear
    add(4'b0100,  0, 17, 0,  0, 1, 4'b0000, 0, 34'h0_00000057, 4'b0000, 1);
    add(4'b0100,  0, 47, 0,  0, 1, 4'b0000, 0, 34'h0_00000057, 4'b0100, 1);
    add(4'b0000,  0, 0,  0,  0, 0, 4'b0000, 1, 34'h2_0000002F, 4'b0100, 1);
    add(4'b0000,  0, 0,  0,  0, 0, 4'b0100, 0, 34'h2_0000002F, 4'b0000, 0);
    // event on the granting edge: both payloads pushed, no overrun
    add(4'b0010,  0, 0, 10,  0, 0, 4'b0000, 0, 34'h2_0000002F, 4'b0000, 1);
    add(4'b0010,  0, 0, 20,  0, 0, 4'b0000, 1, 34'h1_0000000A, 4'b0000, 1);
    add(4'b0000,  0, 0,  0,  0, 0, 4'b0000, 0, 34'h1_0000000A, 4'b0000, 1);
    add(4'b0000,  0, 0,  0,  0, 0, 4'b0000, 1, 34'h1_00000014, 4'b0000, 1);
    add(4'b0000,  0, 0,  0,  0, 0, 4'b0000, 0, 34'h1_00000014, 4'b0000, 0);
    // overrun set coincident with clear: set wins
    add(4'b1000,  5, 0,  0,  0, 1, 4'b0000, 0, 34'h1_00000014, 4'b0000, 1);
    add(4'b1000,  6, 0,  0,  0, 1, 4'b1000, 0, 34'h1_00000014, 4'b1000, 1);
    add(4'b0000,  0, 0,  0,  0, 0, 4'b1000, 1, 34'h3_00000006, 4'b0000, 1);
    add(4'b0000,  0, 0,  0,  0, 0, 4'b0000, 0, 34'h3_00000006, 4'b0000, 0);

    #12 rst_n = 1'b1;
    #1;
    chk("reset_inc", 64'(fifo_write_inc), 64'd0);
    chk("reset_data", 64'(fifo_write_data), 64'd0);
    chk("reset_ov", 64'(overrun), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);

    foreach (vecs[i]) begin
      ev_valid = vecs[i].ev; ev_data = vecs[i].data;
      fifo_write_full = vecs[i].full; overrun_clr = vecs[i].clr;
      step();
      chk($sformatf("vec%0d_inc", i), 64'(fifo_write_inc), 64'(vecs[i].inc));
      chk($sformatf("vec%0d_data", i), 64'(fifo_write_data), 64'(vecs[i].wdata));
      chk($sformatf("vec%0d_ov", i), 64'(overrun), 64'(vecs[i].ov));
      chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].busy));
    end
    ev_valid = '0; ev_data = '0; fifo_write_full = 1'b0; overrun_clr = '0;

    // back-pressure: 20 cycles full while events arrive, then drain in rr order
    fifo_write_full = 1'b1;
    incs = 0;
    for (int c = 0; c < 20; c++) begin
      ev_valid = '0; ev_data = '0;
      if (c == 0)  begin ev_valid = 4'b0001; ev_data[31:0]   = 32'd100; end
      if (c == 5)  begin ev_valid = 4'b0100; ev_data[95:64]  = 32'd300; end
      if (c == 10) begin ev_valid = 4'b1000; ev_data[127:96] = 32'd400; end
      if (c == 15) begin ev_valid = 4'b0010; ev_data[63:32]  = 32'd200; end
      step();
      if (fifo_write_inc) incs++;
    end
    ev_valid = '0; ev_data = '0;
    chk("full_no_push", 64'(incs), 64'd0);
    chk("full_busy", 64'(busy), 64'd1);
    fifo_write_full = 1'b0;
    prev_inc = 1'b0; b2b = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (fifo_write_inc) pushes.push_back(fifo_write_data);
      if (fifo_write_inc && prev_inc) b2b = 1'b1;
      prev_inc = fifo_write_inc;
    end
    exp_push[0] = {2'd0, 32'd100}; exp_push[1] = {2'd1, 32'd200};
    exp_push[2] = {2'd2, 32'd300}; exp_push[3] = {2'd3, 32'd400};
    chk("drain_count", 64'(pushes.size()), 64'd4);
    chk("drain_back_to_back", 64'(b2b), 64'd0);
    for (int k = 0; k < 4; k++)
      chk($sformatf("drain_word%0d", k), (k < pushes.size()) ? 64'(pushes[k]) : 64'hDEAD, 64'(exp_push[k]));
    chk("drain_busy", 64'(busy), 64'd0);

    // reset mid-operation: move rr_ptr to 1, leave 3 pending plus an overrun, then reset
    ev_valid = 4'b0010; ev_data[63:32] = 32'd9;
    step();
    ev_valid = '0; ev_data = '0;
    step();
    step();
    chk("pre_reset_data", 64'(fifo_write_data), 64'({2'd1, 32'd9}));
    fifo_write_full = 1'b1;
    ev_valid = 4'b0111; ev_data = {32'd0, 32'd3, 32'd2, 32'd1};
    step();
    ev_valid = 4'b0001; ev_data = {96'd0, 32'd11};
    step();
    ev_valid = '0; ev_data = '0;
    chk("pre_reset_ov", 64'(overrun), 64'b0001);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_inc", 64'(fifo_write_inc), 64'd0);
    chk("midrst_data", 64'(fifo_write_data), 64'd0);
    chk("midrst_ov", 64'(overrun), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    step();
    #2 rst_n = 1'b1;
    fifo_write_full = 1'b0;
    incs = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (fifo_write_inc || busy) incs++;
    end
    chk("post_rst_idle", 64'(incs), 64'd0);
    ev_valid = 4'b0101; ev_data = {32'd0, 32'd66, 32'd0, 32'd55};
    step();
    ev_valid = '0; ev_data = '0;
    step();
    chk("post_rst_inc", 64'(fifo_write_inc), 64'd1);
    chk("post_rst_first", 64'(fifo_write_data), 64'({2'd0, 32'd55}));
    step();
    step();
    chk("post_rst_second", 64'(fifo_write_data), 64'({2'd2, 32'd66}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
